dds_profile_sequencer: RTL and testbench
========================================

Name: dds_profile_sequencer

Overview:
Controller that programs the Multichannel_DDS register port from a locally stored channel profile. It holds up to MAX_CH frequency tuning words (FTWs) and phase offsets, written by a host. On command it runs a fixed write sequence: disable the DDS, load the FTW and phase registers, re-enable in the selected mode, and optionally pulse sync. It is the only driver of the DDS addr/data/wr_en/sync inputs.

Parameters:
MAX_CH, 32, maximum channel count; matches the DDS 5-bit current_channel.
SYNC_DELAY, 4, idle cycles between the enable write and the sync pulse (>=0).
ADDR_W, 9, DDS register address width.
DATA_W, 24, DDS register data width.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cfg_wr  in  1  host profile write strobe
cfg_sel  in  1  0 = FTW table, 1 = phase table
cfg_idx  in  5  channel index, clog2(MAX_CH)
cfg_data  in  24  table entry
cfg_rej  out  1  1-cycle pulse: host write rejected (busy)
start  in  1  start-sequence strobe
num_ch  in  6  channels to load, valid range 1..MAX_CH
mode  in  2  DDS mode written in the enable word
phase_load  in  1  1 = also load the phase table
sync_en  in  1  1 = issue sync after enable
abort  in  1  abort the running sequence
dds_addr  out  9  DDS register address
dds_data  out  24  DDS register data
dds_wr_en  out  1  DDS write strobe
dds_sync  out  1  DDS sync pulse
busy  out  1  sequence in progress
done  out  1  1-cycle pulse: sequence completed
aborted  out  1  1-cycle pulse: abort completed
err  out  1  1-cycle pulse: start rejected

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, both tables are cleared to 0. Reset mid-sequence forces outputs low immediately and no further writes are issued.
- All outputs are registered.
- When dds_wr_en=0, dds_addr and dds_data are 0.
- Host writes: with cfg_wr high and busy low, the entry is stored next edge, including in the cycle an accepted start is sampled. With cfg_wr high and busy high, the write is dropped and cfg_rej pulses the next cycle.
- start (cycle 0) is accepted only in IDLE with 1<=num_ch<=MAX_CH.
  - On acceptance, mode, num_ch, phase_load and sync_en are latched.
  - Otherwise err pulses in cycle 1 and nothing else happens.
  - start while busy behaves the same way (err pulse, no effect on the running sequence).
- FSM: IDLE -> DIS -> FTW -> PH (skipped if phase_load=0) -> EN -> SYNCW (skipped if sync_en=0) -> DONE -> IDLE. Abort path: ABT_GAP -> ABT_DIS -> IDLE.
- Write cadence: every write is two cycles, wr_en high then wr_en low. Write k (k=0..W-1) has dds_wr_en=1 in cycle 1+2k. The write list is:
  - 0x1FF <= 0 (disable);
  - 0x000+i <= ftw[i], for i=0..N-1;
  - 0x100+i <= ph[i], for i=0..N-1, only if phase_load=1;
  - 0x1FF <= 0x80 | mode (enable).
- W = 2+N, or 2+2N with phase_load=1.
- busy is high from cycle 1 through the done or aborted cycle inclusive.
- Completion with sync_en=0: done pulses in cycle 2W.
- Completion with sync_en=1: dds_sync is high in cycle 2W+SYNC_DELAY and done pulses in cycle 2W+SYNC_DELAY+1.
- abort:
  - Ignored in IDLE; start with abort in IDLE is still accepted.
  - If sampled high in busy cycle c: a write already on the bus in cycle c completes, and no further profile or enable writes are issued.
  - Cycle c+1 is idle. Cycle c+2 writes 0x1FF <= 0. aborted pulses in c+3 and busy drops in c+4.
  - dds_sync is never issued after an abort. done is not pulsed.
  - abort in the done cycle is ignored.
- Table index i wraps only within 0..N-1; entries beyond N-1 are never written to the DDS.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0; err=0; no dds_wr_en.
- Load ftw[0..3]=6711 and ph = 0/4194304/8388608/12582912; start with N=4, mode=01, phase_load=1, sync_en=0 -> 10 writes on odd cycles 1..19, in order 1FF=0, 000..003, 100..103, 1FF=0x000081; done in cycle 20.
- N=6, mode=00, phase_load=0, sync_en=1, SYNC_DELAY=4 -> 8 writes ending 1FF=0x000080 in cycle 15; dds_sync in cycle 20; done in cycle 21.
- start with num_ch=0, then num_ch=33 -> err pulse each time, busy stays 0, no writes.
- Abort in cycle 6 of the N=4 run -> the cycle-5 write completes; no write in cycle 7; write 1FF=0 in cycle 8; aborted in cycle 9; no done, no sync.
- Issue cfg_wr and start while busy -> cfg_rej and err pulse; table contents unchanged; sequence runs to done unaffected.

Source files
------------

// File: rtl/dds_profile_sequencer.sv
// dds_profile_sequencer: holds a host-written FTW/phase profile and replays it
// into the Multichannel_DDS register port as a disable / load / enable / sync
// write sequence, with an abort path that always leaves the DDS disabled.
module dds_profile_sequencer #(
    parameter int MAX_CH     = 32,
    parameter int SYNC_DELAY = 4,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 24,
    localparam int IDX_W     = $clog2(MAX_CH),
    localparam int NUM_W     = $clog2(MAX_CH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic              cfg_sel,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_rej,
    input  logic              start,
    input  logic [NUM_W-1:0]  num_ch,
    input  logic [1:0]        mode,
    input  logic              phase_load,
    input  logic              sync_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] dds_addr,
    output logic [DATA_W-1:0] dds_data,
    output logic              dds_wr_en,
    output logic              dds_sync,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    localparam int CNT_W = $clog2(SYNC_DELAY + 2);

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'('h1FF);
    localparam logic [ADDR_W-1:0] PH_BASE     = ADDR_W'('h100);
    localparam logic [DATA_W-1:0] ENABLE_WORD = DATA_W'('h80);

    // Each write state spans two cycles: half=0 drives the strobe, half=1 is the gap.
    typedef enum logic [3:0] {
        IDLE,
        DIS,
        FTW,
        PH,
        EN,
        SYNCW,
        DONE,
        ABT_GAP,
        ABT_DIS
    } state_t;

    state_t state, state_n;
    logic half, half_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [NUM_W-1:0] num_q;
    logic [1:0]       mode_q;
    logic             phase_q;
    logic             sync_q;

    logic [DATA_W-1:0] ftw_tab [MAX_CH];
    logic [DATA_W-1:0] ph_tab  [MAX_CH];

    logic              start_ok;
    logic              abort_ok;
    logic              last_idx;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic              wr_n;
    logic              sync_n;
    logic              busy_n;
    logic              done_n;
    logic              aborted_n;
    logic              err_n;
    logic              rej_n;

    assign start_ok = start && (state == IDLE) && (num_ch != '0)
                      && (num_ch <= NUM_W'(MAX_CH));
    assign abort_ok = abort && (state inside {DIS, FTW, PH, EN, SYNCW});
    assign last_idx = (NUM_W'(idx) == (num_q - NUM_W'(1)));

    // Profile tables: host writes land only while no sequence is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_CH; i++) begin
                ftw_tab[i] <= '0;
                ph_tab[i]  <= '0;
            end
        end else if (cfg_wr && !busy) begin
            if (cfg_sel) ph_tab[cfg_idx]  <= cfg_data;
            else         ftw_tab[cfg_idx] <= cfg_data;
        end
    end

    // Snapshot the run configuration when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q   <= '0;
            mode_q  <= '0;
            phase_q <= 1'b0;
            sync_q  <= 1'b0;
        end else if (start_ok) begin
            num_q   <= num_ch;
            mode_q  <= mode;
            phase_q <= phase_load;
            sync_q  <= sync_en;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            half  <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            half  <= half_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, then the registered outputs derived from that next state.
    always_comb begin
        state_n = state;
        half_n  = half;
        idx_n   = idx;
        cnt_n   = cnt;

        if (abort_ok) begin
            state_n = ABT_GAP;
            half_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state_n = DIS;
                        half_n  = 1'b0;
                        idx_n   = '0;
                    end
                end
                DIS: begin
                    if (!half) begin
                        half_n = 1'b1;
                    end else begin
                        half_n  = 1'b0;
                        state_n = FTW;
                        idx_n   = '0;
                    end
                end
                FTW: begin
                    if (!half) begin
                        half_n = 1'b1;
                    end else begin
                        half_n = 1'b0;
                        if (last_idx) begin
                            idx_n   = '0;
                            state_n = phase_q ? PH : EN;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end
                end
                PH: begin
                    if (!half) begin
                        half_n = 1'b1;
                    end else begin
                        half_n = 1'b0;
                        if (last_idx) begin
                            idx_n   = '0;
                            state_n = EN;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end
                end
                EN: begin
                    // The enable write's gap cycle doubles as the done cycle or first sync wait.
                    half_n = 1'b0;
                    if (sync_q) begin
                        state_n = SYNCW;
                        cnt_n   = '0;
                    end else begin
                        state_n = DONE;
                    end
                end
                SYNCW: begin
                    if (cnt == CNT_W'(SYNC_DELAY)) state_n = DONE;
                    else                           cnt_n   = cnt + CNT_W'(1);
                end
                DONE: begin
                    state_n = IDLE;
                end
                ABT_GAP: begin
                    state_n = ABT_DIS;
                    half_n  = 1'b0;
                end
                ABT_DIS: begin
                    if (!half) begin
                        half_n = 1'b1;
                    end else begin
                        half_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    half_n  = 1'b0;
                end
            endcase
        end

        wr_n      = 1'b0;
        addr_n    = '0;
        data_n    = '0;
        sync_n    = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;

        case (state_n)
            DIS, ABT_DIS: begin
                if (!half_n) begin
                    wr_n   = 1'b1;
                    addr_n = CTRL_ADDR;
                end
                aborted_n = (state_n == ABT_DIS) && half_n;
            end
            FTW: begin
                if (!half_n) begin
                    wr_n   = 1'b1;
                    addr_n = ADDR_W'(idx_n);
                    data_n = ftw_tab[idx_n];
                end
            end
            PH: begin
                if (!half_n) begin
                    wr_n   = 1'b1;
                    addr_n = PH_BASE | ADDR_W'(idx_n);
                    data_n = ph_tab[idx_n];
                end
            end
            EN: begin
                if (!half_n) begin
                    wr_n   = 1'b1;
                    addr_n = CTRL_ADDR;
                    data_n = ENABLE_WORD | DATA_W'(mode_q);
                end
            end
            SYNCW:   sync_n = (cnt_n == CNT_W'(SYNC_DELAY));
            DONE:    done_n = 1'b1;
            default: ;
        endcase

        busy_n = (state_n != IDLE);
        err_n  = start && !start_ok;
        rej_n  = cfg_wr && busy;
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dds_addr  <= '0;
            dds_data  <= '0;
            dds_wr_en <= 1'b0;
            dds_sync  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
            cfg_rej   <= 1'b0;
        end else begin
            dds_addr  <= addr_n;
            dds_data  <= data_n;
            dds_wr_en <= wr_n;
            dds_sync  <= sync_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
            err       <= err_n;
            cfg_rej   <= rej_n;
        end
    end

endmodule

// File: tb/tb_dds_profile_sequencer.sv
// tb_dds_profile_sequencer: drives directed and random profile runs and compares
// every cycle of the DDS port against a trace predicted from the write-list rules.
module tb_dds_profile_sequencer;

    localparam int MAX_CH     = 32;
    localparam int SYNC_DELAY = 4;
    localparam int MAXT       = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic [23:0] cfg_data = '0;
    logic        cfg_rej;
    logic        start = 1'b0;
    logic [5:0]  num_ch = '0;
    logic [1:0]  mode = '0;
    logic        phase_load = 1'b0;
    logic        sync_en = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  dds_addr;
    logic [23:0] dds_data;
    logic        dds_wr_en;
    logic        dds_sync;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err;

    int total = 0;
    int bad = 0;

    logic [23:0] m_ftw [MAX_CH];
    logic [23:0] m_ph  [MAX_CH];
    logic [39:0] exp_v [MAXT];
    logic [39:0] act_v [MAXT];
    int          seq_len;

    always #5 clk = ~clk;

    dds_profile_sequencer #(
        .MAX_CH(MAX_CH), .SYNC_DELAY(SYNC_DELAY), .ADDR_W(9), .DATA_W(24)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_rej(cfg_rej),
        .start(start), .num_ch(num_ch), .mode(mode), .phase_load(phase_load),
        .sync_en(sync_en), .abort(abort),
        .dds_addr(dds_addr), .dds_data(dds_data), .dds_wr_en(dds_wr_en),
        .dds_sync(dds_sync), .busy(busy), .done(done), .aborted(aborted), .err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Snapshot of every output: {busy, wr_en, addr, data, sync, done, aborted, err, cfg_rej}
    function automatic logic [39:0] obs();
        return {busy, dds_wr_en, dds_addr, dds_data, dds_sync, done, aborted, err, cfg_rej};
    endfunction

    task automatic host_write(input bit sel, input int idx, input logic [23:0] data);
        cfg_wr   = 1'b1;
        cfg_sel  = sel;
        cfg_idx  = 5'(idx);
        cfg_data = data;
        tick;
        cfg_wr = 1'b0;
        if (sel) m_ph[idx] = data;
        else     m_ftw[idx] = data;
    endtask

    task automatic clear_model;
        for (int i = 0; i < MAX_CH; i++) begin
            m_ftw[i] = '0;
            m_ph[i]  = '0;
        end
    endtask

    // Expected trace for cycles 1..seq_len, built from the ordered write list.
    task automatic build_expect(input int n, input int md, input bit pl, input bit se,
                                input int ac_in, input int rc);
        logic [8:0]  wa[$];
        logic [23:0] wd[$];
        int w, done_c, last, ac;
        logic b, wr, s, dn, ab, e, r;
        logic [8:0]  a;
        logic [23:0] d;
        wa.push_back(9'h1FF); wd.push_back(24'h0);
        for (int i = 0; i < n; i++) begin
            wa.push_back(9'(i)); wd.push_back(m_ftw[i]);
        end
        if (pl) begin
            for (int i = 0; i < n; i++) begin
                wa.push_back(9'h100 + 9'(i)); wd.push_back(m_ph[i]);
            end
        end
        wa.push_back(9'h1FF); wd.push_back(24'h80 | 24'(md));
        w      = wa.size();
        done_c = se ? 2 * w + SYNC_DELAY + 1 : 2 * w;
        ac     = (ac_in >= done_c) ? 0 : ac_in;
        last   = (ac > 0) ? ac + 3 : done_c;
        seq_len = last + 2;
        for (int t = 1; t <= seq_len; t++) begin
            b = (t <= last); wr = 0; a = '0; d = '0; s = 0; dn = 0; ab = 0;
            e = (rc > 0) && (t == rc + 1);
            r = e;
            if (ac == 0 || t <= ac) begin
                if ((t % 2 == 1) && (t <= 2 * w - 1)) begin
                    wr = 1; a = wa[(t - 1) / 2]; d = wd[(t - 1) / 2];
                end
                if (se && t == 2 * w + SYNC_DELAY) s = 1;
                if (ac == 0 && t == done_c) dn = 1;
            end else begin
                if (t == ac + 2) begin wr = 1; a = 9'h1FF; end
                if (t == ac + 3) ab = 1;
            end
            exp_v[t] = {b, wr, a, d, s, dn, ab, e, r};
        end
    endtask

    // Runs one sequence: start in cycle 0, optional abort in cycle ac, optional
    // rejected host write + start in cycle rc, optional abort in cycle 0.
    task automatic run_seq(input int n, input int md, input bit pl, input bit se,
                           input int ac, input int rc, input bit ab0,
                           input bit pw, input bit pw_sel, input int pw_idx,
                           input logic [23:0] pw_data);
        if (pw) begin
            if (pw_sel) m_ph[pw_idx] = pw_data;
            else        m_ftw[pw_idx] = pw_data;
        end
        build_expect(n, md, pl, se, ac, rc);
        start = 1'b1; num_ch = 6'(n); mode = 2'(md); phase_load = pl; sync_en = se;
        abort = ab0;
        cfg_wr = pw; cfg_sel = pw_sel; cfg_idx = 5'(pw_idx); cfg_data = pw_data;
        for (int t = 1; t <= seq_len; t++) begin
            tick;
            act_v[t] = obs();
            start = 1'b0; cfg_wr = 1'b0; abort = (t == ac);
            num_ch = 6'($urandom); mode = 2'($urandom);
            phase_load = 1'($urandom); sync_en = 1'($urandom);
            if (t == rc) begin
                start = 1'b1; cfg_wr = 1'b1; cfg_sel = 1'($urandom);
                cfg_idx = 5'($urandom); cfg_data = 24'($urandom);
            end
        end
        start = 1'b0; cfg_wr = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        total++;
        if (obs() !== 40'h0) begin
            bad++; $display("[TB] FAIL reset_hold: got %h want %h", obs(), 40'h0);
        end
        reset = 1'b0;
        clear_model();
        for (int t = 0; t < 10; t++) begin
            tick;
            total++;
            if (obs() !== 40'h0) begin
                bad++; $display("[TB] FAIL reset_idle cycle %0d: got %h want %h", t, obs(), 40'h0);
            end
        end
    endtask

    task automatic test_profile;
        for (int i = 0; i < 4; i++) host_write(0, i, 24'd6711);
        host_write(1, 0, 24'd0);
        host_write(1, 1, 24'd4194304);
        host_write(1, 2, 24'd8388608);
        host_write(1, 3, 24'd12582912);
        run_seq(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 24'h0);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL profile cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_sync;
        host_write(0, 4, 24'($urandom));
        host_write(0, 5, 24'($urandom));
        run_seq(6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 24'h0);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL sync cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_bad_start;
        int bad_n[3] = '{0, 33, 63};
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; num_ch = 6'(bad_n[k]); mode = 2'd1; phase_load = 1'b1; sync_en = 1'b1;
            tick;
            start = 1'b0;
            total++;
            if (obs() !== 40'h2) begin
                bad++; $display("[TB] FAIL bad_start_err n=%0d: got %h want %h", bad_n[k], obs(), 40'h2);
            end
            tick;
            total++;
            if (obs() !== 40'h0) begin
                bad++; $display("[TB] FAIL bad_start_quiet n=%0d: got %h want %h", bad_n[k], obs(), 40'h0);
            end
        end
    endtask

    task automatic test_abort;
        run_seq(4, 1, 1, 0, 6, 0, 0, 0, 0, 0, 24'h0);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL abort cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
        run_seq(3, 2, 0, 1, 0, 0, 1, 0, 0, 0, 24'h0);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL abort_idle cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
        run_seq(2, 3, 0, 0, 8, 0, 0, 0, 0, 0, 24'h0);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL abort_done cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_back_to_back;
        run_seq(4, 1, 1, 1, 0, 5, 0, 1, 1, 2, 24'h5A5A5A);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL busy_rej cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
        run_seq(4, 2, 1, 0, 0, 0, 0, 0, 0, 0, 24'h0);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL table_kept cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1; num_ch = 6'd8; mode = 2'd3; phase_load = 1'b1; sync_en = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs() !== 40'h0) begin
            bad++; $display("[TB] FAIL reset_mid: got %h want %h", obs(), 40'h0);
        end
        tick; tick;
        reset = 1'b0;
        clear_model();
        tick;
        run_seq(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 24'h0);
        for (int t = 1; t <= seq_len; t++) begin
            total++;
            if (act_v[t] !== exp_v[t]) begin
                bad++; $display("[TB] FAIL reset_clear cycle %0d: got %h want %h", t, act_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_random;
        int n, md, w, done_c, ac, last, rc;
        bit pl, se, pw;
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < 4; k++)
                host_write(1'($urandom), $urandom_range(MAX_CH - 1, 0), 24'($urandom));
            n  = $urandom_range(MAX_CH, 1);
            md = $urandom_range(3, 0);
            pl = 1'($urandom);
            se = 1'($urandom);
            w  = pl ? 2 + 2 * n : 2 + n;
            done_c = se ? 2 * w + SYNC_DELAY + 1 : 2 * w;
            ac = ($urandom_range(1, 0) == 1) ? $urandom_range(done_c, 1) : 0;
            last = (ac > 0 && ac < done_c) ? ac + 3 : done_c;
            rc = ($urandom_range(2, 0) == 0) ? $urandom_range(last, 1) : 0;
            pw = 1'($urandom);
            run_seq(n, md, pl, se, ac, rc, 0, pw, 1'($urandom),
                    $urandom_range(MAX_CH - 1, 0), 24'($urandom));
            for (int t = 1; t <= seq_len; t++) begin
                total++;
                if (act_v[t] !== exp_v[t]) begin
                    bad++;
                    $display("[TB] FAIL random it=%0d n=%0d cycle %0d: got %h want %h",
                             it, n, t, act_v[t], exp_v[t]);
                end
            end
            tick;
        end
    endtask

    initial begin
        test_reset();
        test_profile();
        test_sync();
        test_bad_start();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
